instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Fetch stage plus IF/ID register. Holds the PC, issues requests to instruction memory over a req/ack handshake, and registers each returned word.
//  Splits each word into MIPS fields. id_imm16 is the 16-bit immediate consumed by the sign-extension stage directly downstream.
//  Supports downstream stall, flush/redirect, and a one-entry skid buffer so no returned word is lost.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  PC_STEP    4              byte increment between sequential fetches
// PORTS
//  clk          in   1   single clock; all state updates on rising edge
//  rst_n        in   1   synchronous, active-low reset
//  imem_req     out  1   fetch request; held until imem_ack
//  imem_addr    out  32  fetch address; stable while imem_req=1
//  imem_ack     in   1   rdata valid this cycle; may be same cycle as req
//  imem_rdata   in   32  instruction word
//  stall        in   1   downstream cannot accept; ID register holds
//  flush        in   1   discard ID, skid and in-flight word; redirect PC
//  redirect_pc  in   32  new fetch PC, sampled when flush=1
//  id_valid     out  1   ID register holds a valid instruction
//  id_pc        out  32  address of id_instr
//  id_pc_plus4  out  32  id_pc + PC_STEP
//  id_instr     out  32  raw word
//  id_opcode/id_rs/id_rt/id_rd/id_funct  out 6/5/5/5/6  fields [31:26]/[25:21]/[20:16]/[15:11]/[5:0]
//  id_imm16     out  16  [15:0], to sign-extension stage
//  id_target    out  26  [25:0] jump target
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=S_BOOT, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, id_valid=0, all id_* =0, skid empty, drop=0.
//  FSM: S_BOOT -> S_REQ (one cycle). In S_REQ, imem_req=1 and imem_addr=pc.
//   S_REQ + ack + slot free -> capture; pc+=PC_STEP; remain in S_REQ.
//   S_REQ + ack + ID full & stall -> write skid; go to S_HOLD.
//   S_HOLD: imem_req=0. When stall=0, skid moves to ID, skid empties, go to S_REQ.
//  Slot free = !id_valid || !stall. Latency: ack in cycle N -> id_valid=1 in cycle N+1.
//  Zero-wait memory (ack every cycle) sustains 1 instr/cycle.
//  Stall with id_valid=1: all id_* hold. Stall with id_valid=0: next word still loads.
//  ID consumed (id_valid & !stall) with no new word -> id_valid=0 next cycle.
//  Flush (priority over stall and ack): next cycle id_valid=0, skid empty, pc=redirect_pc, state=S_REQ.
//   If req outstanding without ack in flush cycle: drop=1, imem_addr held until that ack. Acked word discarded, then redirect_pc requested.
//   Ack in flush cycle: word discarded.
//  Reset mid-request overrides everything; the in-flight ack is ignored, since imem must also be reset.
//  PC arithmetic is modulo 2^32 (0xFFFF_FFFC + 4 wraps to 0). No alignment check.
// CONFIGURATION
//  IF_PERF_CNT_EN defined: adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0], both reset to 0.
//   perf_fetch_cnt increments per word accepted into ID or skid.
//   perf_stall_cnt increments per cycle with id_valid & stall.
//   Both wrap at 2^32.
//  IF_PERF_CNT_EN undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  Shared package cpu_pkg (cpu_defs.vh): field bit positions, FSM state encodings (S_BOOT/S_REQ/S_HOLD), default RESET_PC, PC_STEP.
//  Sub-module if_field_split: combinational decode of a 32-bit word into opcode/rs/rt/rd/funct/imm16/target, shared with later decode.
//  Top level owns PC, FSM, skid buffer, drop flag and ID register.
// TESTING
//  1 Reset, then zero-wait memory returning 0x2008_FFFF at 0x0 -> cycle 2: id_valid=1, id_pc=0, id_imm16=0xFFFF, id_rt=8, imem_addr=0x4.
//  2 Ack every cycle for 8 words -> id_pc=0,4,...,0x1C on consecutive cycles; no bubbles.
//  3 stall=1 while ID full and a word is acked -> skid captures it, imem_req=0. stall=0 -> skid word in ID next cycle, fetch resumes at next PC.
//  4 flush with redirect_pc=0x400 while request to 0x10 awaits ack (3-cycle memory) -> addr stays 0x10 until ack, word dropped, next req addr 0x400, id_valid never 1 for 0x10.
//  5 flush and ack in same cycle, and flush with stall=1 -> id_valid=0 next cycle, next id_pc=redirect_pc.
//  6 RESET_PC=0xFFFF_FFFC -> second fetch addr 0x0. With IF_PERF_CNT_EN, perf_fetch_cnt=2 after both words accepted.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cpu_pkg                                                       |
// | Purpose  : Shared CPU definitions: MIPS instruction field positions,    |
// |            fetch FSM state encoding, default reset PC and PC step.       |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package cpu_pkg;

    // Fetch defaults
    localparam logic [31:0] c_reset_pc_default = 32'h0000_0000;
    localparam logic [31:0] c_pc_step_default  = 32'd4;

    // MIPS field bit positions
    localparam int c_opcode_msb = 31;
    localparam int c_opcode_lsb = 26;
    localparam int c_rs_msb     = 25;
    localparam int c_rs_lsb     = 21;
    localparam int c_rt_msb     = 20;
    localparam int c_rt_lsb     = 16;
    localparam int c_rd_msb     = 15;
    localparam int c_rd_lsb     = 11;
    localparam int c_funct_msb  = 5;
    localparam int c_funct_lsb  = 0;
    localparam int c_imm_msb    = 15;
    localparam int c_imm_lsb    = 0;
    localparam int c_tgt_msb    = 25;
    localparam int c_tgt_lsb    = 0;

    // Fetch FSM state encoding
    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/if_field_split.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : if_field_split                                                |
// | Purpose  : Combinational split of a 32-bit MIPS word into its fields.    |
// |            Shared by fetch and later decode.                             |
// | Ports    : instr  in  32  raw instruction word                           |
// |            opcode out 6, rs/rt/rd out 5, funct out 6, imm16 out 16,      |
// |            target out 26                                                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module if_field_split
    import cpu_pkg::*;
(
    input  logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [25:0] target
);

    assign opcode = instr[c_opcode_msb:c_opcode_lsb];
    assign rs     = instr[c_rs_msb:c_rs_lsb];
    assign rt     = instr[c_rt_msb:c_rt_lsb];
    assign rd     = instr[c_rd_msb:c_rd_lsb];
    assign funct  = instr[c_funct_msb:c_funct_lsb];
    assign imm16  = instr[c_imm_msb:c_imm_lsb];
    assign target = instr[c_tgt_msb:c_tgt_lsb];

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : instr_fetch                                                   |
// | Purpose  : Fetch stage and IF/ID register. Owns the PC, the fetch FSM,   |
// |            a one-entry skid buffer and the drop flag used to discard a   |
// |            word still in flight when a flush arrives.                    |
// | Ports    : clk, rst_n (sync, active low)                                 |
// |            imem_req/imem_addr out, imem_ack/imem_rdata in                |
// |            stall, flush, redirect_pc in                                  |
// |            id_valid, id_pc, id_pc_plus4, id_instr and decoded fields out |
// |            perf_fetch_cnt, perf_stall_cnt out (only with IF_PERF_CNT_EN) |
// | Config   : IF_PERF_CNT_EN adds the two performance counters.             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_reset_pc_default,
    parameter logic [31:0] PC_STEP  = c_pc_step_default
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] id_instr,
    output logic [5:0]  id_opcode,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [5:0]  id_funct,
    output logic [15:0] id_imm16,
    output logic [25:0] id_target
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    fetch_state_t r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt;
    logic         r_drop, w_drop_nxt;
    logic [31:0]  r_drop_addr, w_drop_addr_nxt;
    logic [31:0]  r_skid_instr, w_skid_instr_nxt;
    logic [31:0]  r_skid_pc, w_skid_pc_nxt;
    logic         r_id_valid, w_id_valid_nxt;
    logic [31:0]  r_id_pc, w_id_pc_nxt;
    logic [31:0]  r_id_pc_plus4, w_id_pc_plus4_nxt;
    logic [31:0]  r_id_instr, w_id_instr_nxt;
    logic         w_slot_free;

    // While dropping, the old address must stay on the bus until its ack,
    // even though r_pc already holds the redirect target.
    assign imem_req    = (r_state == S_REQ);
    assign imem_addr   = r_drop ? r_drop_addr : r_pc;
    assign w_slot_free = !r_id_valid || !stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_PC;
            r_drop        <= 1'b0;
            r_drop_addr   <= RESET_PC;
            r_skid_instr  <= '0;
            r_skid_pc     <= '0;
            r_id_valid    <= 1'b0;
            r_id_pc       <= '0;
            r_id_pc_plus4 <= '0;
            r_id_instr    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_drop        <= w_drop_nxt;
            r_drop_addr   <= w_drop_addr_nxt;
            r_skid_instr  <= w_skid_instr_nxt;
            r_skid_pc     <= w_skid_pc_nxt;
            r_id_valid    <= w_id_valid_nxt;
            r_id_pc       <= w_id_pc_nxt;
            r_id_pc_plus4 <= w_id_pc_plus4_nxt;
            r_id_instr    <= w_id_instr_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_drop_nxt        = r_drop;
        w_drop_addr_nxt   = r_drop_addr;
        w_skid_instr_nxt  = r_skid_instr;
        w_skid_pc_nxt     = r_skid_pc;
        w_id_valid_nxt    = r_id_valid;
        w_id_pc_nxt       = r_id_pc;
        w_id_pc_plus4_nxt = r_id_pc_plus4;
        w_id_instr_nxt    = r_id_instr;

        // Downstream consumed the ID word; a new capture below overrides this.
        if (r_id_valid && !stall) begin
            w_id_valid_nxt = 1'b0;
        end

        if (flush) begin
            w_id_valid_nxt = 1'b0;
            w_state_nxt    = S_REQ;
            w_pc_nxt       = redirect_pc;
            // An unacked request cannot be withdrawn; remember it so its
            // eventual ack is swallowed. An ack this cycle closes it.
            if (imem_req && !imem_ack) begin
                w_drop_nxt      = 1'b1;
                w_drop_addr_nxt = imem_addr;
            end else begin
                w_drop_nxt = 1'b0;
            end
        end else begin
            case (r_state)
                S_BOOT: begin
                    w_state_nxt = S_REQ;
                end
                S_REQ: begin
                    if (imem_ack) begin
                        if (r_drop) begin
                            w_drop_nxt = 1'b0;
                        end else if (w_slot_free) begin
                            w_id_valid_nxt    = 1'b1;
                            w_id_pc_nxt       = r_pc;
                            w_id_pc_plus4_nxt = r_pc + PC_STEP;
                            w_id_instr_nxt    = imem_rdata;
                            w_pc_nxt          = r_pc + PC_STEP;
                        end else begin
                            w_skid_instr_nxt = imem_rdata;
                            w_skid_pc_nxt    = r_pc;
                            w_pc_nxt         = r_pc + PC_STEP;
                            w_state_nxt      = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        w_id_valid_nxt    = 1'b1;
                        w_id_pc_nxt       = r_skid_pc;
                        w_id_pc_plus4_nxt = r_skid_pc + PC_STEP;
                        w_id_instr_nxt    = r_skid_instr;
                        w_state_nxt       = S_REQ;
                    end
                end
                default: begin
                    w_state_nxt = S_BOOT;
                end
            endcase
        end
    end

    assign id_valid    = r_id_valid;
    assign id_pc       = r_id_pc;
    assign id_pc_plus4 = r_id_pc_plus4;
    assign id_instr    = r_id_instr;

    if_field_split u_field_split (
        .instr  (r_id_instr),
        .opcode (id_opcode),
        .rs     (id_rs),
        .rt     (id_rt),
        .rd     (id_rd),
        .funct  (id_funct),
        .imm16  (id_imm16),
        .target (id_target)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;
    logic        w_accept;

    // A word is accepted when it lands in ID or skid: live ack in S_REQ
    // that is neither being dropped nor killed by a flush.
    assign w_accept = imem_req && imem_ack && !r_drop && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_fetch <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_accept) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (r_id_valid && stall) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_stall_cnt = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_instr_fetch                                                |
// | Purpose  : Self-checking bench for instr_fetch. A memory responder with  |
// |            selectable latency feeds the main DUT; a second DUT with     |
// |            RESET_PC=0xFFFF_FFFC sees zero-wait memory to exercise wrap. |
// |            A stream model checks every consumed ID word against the     |
// |            expected in-order address sequence.                           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_instr_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, stall, flush, imem_ack;
    logic [31:0] redirect_pc, imem_rdata;
    wire         imem_req, id_valid;
    wire  [31:0] imem_addr, id_pc, id_pc_plus4, id_instr;
    wire  [5:0]  id_opcode, id_funct;
    wire  [4:0]  id_rs, id_rt, id_rd;
    wire  [15:0] id_imm16;
    wire  [25:0] id_target;

    wire         w_req, wid_valid;
    wire  [31:0] w_addr, wid_pc, wid_pc4, wid_instr;
    wire  [5:0]  wid_opcode, wid_funct;
    wire  [4:0]  wid_rs, wid_rt, wid_rd;
    wire  [15:0] wid_imm16;
    wire  [25:0] wid_target;
    logic        w_ack;
    logic [31:0] w_rdata;
`ifdef IF_PERF_CNT_EN
    wire  [31:0] perf_fetch_cnt, perf_stall_cnt, w_perf_fetch, w_perf_stall;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_FFFF;
        return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    instr_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
        .id_instr(id_instr), .id_opcode(id_opcode), .id_rs(id_rs),
        .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct),
        .id_imm16(id_imm16), .id_target(id_target)
`ifdef IF_PERF_CNT_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_ack), .imem_rdata(w_rdata),
        .stall(1'b0), .flush(1'b0), .redirect_pc(32'h0),
        .id_valid(wid_valid), .id_pc(wid_pc), .id_pc_plus4(wid_pc4),
        .id_instr(wid_instr), .id_opcode(wid_opcode), .id_rs(wid_rs),
        .id_rt(wid_rt), .id_rd(wid_rd), .id_funct(wid_funct),
        .id_imm16(wid_imm16), .id_target(wid_target)
`ifdef IF_PERF_CNT_EN
        , .perf_fetch_cnt(w_perf_fetch), .perf_stall_cnt(w_perf_stall)
`endif
    );

    // Zero-wait memory for the wrap instance
    always_comb begin
        w_ack   = w_req;
        w_rdata = mem_word(w_addr);
    end

    // Memory responder for the main DUT. mem_mode: 0 zero-wait,
    // 1 fixed three-cycle request, 2 random 1..3 cycles.
    int mem_mode = 0;
    int wait_cnt = 0;

    function automatic int pick_lat(input int mode);
        if (mode == 0) return 0;
        if (mode == 1) return 2;
        return int'($urandom_range(0, 2));
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            imem_ack = 1'b0;
            wait_cnt = pick_lat(mem_mode);
        end else if (imem_req) begin
            if (wait_cnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                wait_cnt   = pick_lat(mem_mode);
            end else begin
                imem_ack = 1'b0;
                wait_cnt = wait_cnt - 1;
            end
        end else begin
            imem_ack = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Stream model state
    logic [31:0] exp_pc = 32'h0;
    bit          held = 1'b0;
    logic [31:0] held_pc, held_instr;
    int          n_consumed = 0;
    bit          p_req, p_ack, p_rst;
    logic [31:0] p_addr;

    // Evaluates the current cycle (inputs already driven), then advances
    // to 1 time unit after the next rising edge.
    task automatic cycle();
        logic [31:0] w;
        if (held) begin
            chk("hold_valid", id_valid, 1);
            chk("hold_pc", id_pc, held_pc);
            chk("hold_instr", id_instr, held_instr);
        end
        held = 1'b0;
        if (!rst_n) begin
            exp_pc = 32'h0;
        end else if (flush) begin
            exp_pc = redirect_pc;
        end else if (id_valid && !stall) begin
            w = mem_word(exp_pc);
            chk("stream_pc", id_pc, exp_pc);
            chk("stream_pc4", id_pc_plus4, exp_pc + 32'd4);
            chk("stream_instr", id_instr, w);
            chk("stream_fields", {id_opcode, id_rs, id_rt, id_rd, id_funct, id_imm16[4:0]},
                {w[31:26], w[25:21], w[20:16], w[15:11], w[5:0], w[4:0]});
            chk("stream_imm_tgt", {id_imm16, id_target[15:0]}, {w[15:0], w[15:0]});
            exp_pc = exp_pc + 32'd4;
            n_consumed++;
        end else if (id_valid && stall) begin
            held       = 1'b1;
            held_pc    = id_pc;
            held_instr = id_instr;
        end
        @(negedge clk); #1;
        p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr; p_rst = rst_n;
        @(posedge clk); #1;
        if (p_rst && rst_n && p_req && !p_ack) begin
            chk("req_held", imem_req, 1);
            chk("addr_stable", imem_addr, p_addr);
        end
    endtask

    initial begin
        bit found;
        int rand_base;
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect_pc = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0;

        // Reset state
        @(posedge clk); #1;
        cycle();
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", id_valid, 0);
        chk("rst_pc", id_pc, 0);
        chk("rst_pc4", id_pc_plus4, 0);
        chk("rst_instr", id_instr, 0);
        chk("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);
`ifdef IF_PERF_CNT_EN
        chk("rst_perf_fetch", perf_fetch_cnt, 0);
        chk("rst_perf_stall", perf_stall_cnt, 0);
`endif

        // First fetch latency and field split
        rst_n = 1'b1;
        chk("boot_req", imem_req, 0);
        cycle();
        chk("c1_req", imem_req, 1);
        chk("c1_addr", imem_addr, 32'h0);
        cycle();
        chk("c2_valid", id_valid, 1);
        chk("c2_pc", id_pc, 32'h0);
        chk("c2_imm16", id_imm16, 32'hFFFF);
        chk("c2_rt", id_rt, 8);
        chk("c2_addr", imem_addr, 32'h4);
        chk("wrap_pc0", wid_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", wid_pc4, 32'h0);
        chk("wrap_addr1", w_addr, 32'h0);
        cycle();
        chk("wrap_pc1", wid_pc, 32'h0);
`ifdef IF_PERF_CNT_EN
        chk("wrap_perf_fetch", w_perf_fetch, 2);
`endif

        // Back-to-back fetch, no bubbles
        chk("b2b_pc1", id_pc, 32'h4);
        for (int k = 2; k < 8; k++) begin
            cycle();
            chk("b2b_valid", id_valid, 1);
            chk("b2b_pc", id_pc, 32'(4 * k));
        end

        // Skid buffer under stall
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("skid_req", imem_req, 0);
            chk("skid_hold_pc", id_pc, 32'h1C);
        end
        stall = 1'b0;
        cycle();
        chk("skid_out_pc", id_pc, 32'h20);
        chk("skid_resume_addr", imem_addr, 32'h24);
        cycle();
        chk("skid_next_pc", id_pc, 32'h24);
`ifdef IF_PERF_CNT_EN
        chk("perf_stall", perf_stall_cnt, 3);
`endif

        // Flush coinciding with ack
        flush = 1'b1; redirect_pc = 32'h800;
        cycle();
        flush = 1'b0;
        chk("fa_valid", id_valid, 0);
        chk("fa_addr", imem_addr, 32'h800);
        cycle();
        chk("fa_pc", id_pc, 32'h800);

        // Flush while stalled
        stall = 1'b1; flush = 1'b1; redirect_pc = 32'hC00;
        cycle();
        flush = 1'b0;
        chk("fs_valid", id_valid, 0);
        cycle();
        chk("fs_valid2", id_valid, 1);
        chk("fs_pc", id_pc, 32'hC00);
        stall = 1'b0;
        cycle();

        // Flush while request to 0x10 is outstanding (3-cycle memory)
        mem_mode = 1;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (imem_req && imem_addr == 32'h10) found = 1'b1;
            else cycle();
        end
        chk("drop_reach", found, 1);
        flush = 1'b1; redirect_pc = 32'h400;
        cycle();
        flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("drop_addr", imem_addr, 32'h10);
            chk("drop_req", imem_req, 1);
            chk("drop_valid", id_valid, 0);
            cycle();
        end
        chk("redir_addr", imem_addr, 32'h400);
        chk("redir_valid", id_valid, 0);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (id_valid) found = 1'b1;
            else cycle();
        end
        chk("redir_seen", found, 1);
        chk("redir_pc", id_pc, 32'h400);
        chk("redir_instr", id_instr, mem_word(32'h400));

        // Randomized traffic under the stream model
        mem_mode = 2;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        rand_base = n_consumed;
        for (int k = 0; k < 1500; k++) begin
            stall = ($urandom_range(0, 9) < 3);
            flush = ($urandom_range(0, 39) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0
                                                      : ($urandom & 32'h0000_FFFC);
            cycle();
        end
        stall = 1'b0; flush = 1'b0;
        chk("rand_progress", (n_consumed - rand_base) > 200, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
